// File: rtl/sprite_pkg.sv
// Sprite ID constants, rom_sel encodings and the ID-to-ROM mapping shared by the
// sprite fetch arbiter and its users.
package sprite_pkg;

  localparam logic [4:0] ID_SHIP = 5'd0;
  localparam logic [4:0] ID_PIG  = 5'd2;
  localparam logic [4:0] ID_BEE  = 5'd3;

  typedef enum logic [1:0] {
    SEL_SHIP = 2'd0,
    SEL_PIG  = 2'd1,
    SEL_BEE  = 2'd2,
    SEL_NONE = 2'd3
  } rom_sel_e;

  // Unknown IDs fall through to SEL_NONE, which reads back as a transparent pixel.
  function automatic rom_sel_e id_to_sel(input logic [4:0] id);
    case (id)
      ID_SHIP: return SEL_SHIP;
      ID_PIG:  return SEL_PIG;
      ID_BEE:  return SEL_BEE;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sprite_fetch_arbiter_if.sv
// Request/grant/ROM/response bundle between sprite slots, the arbiter and the sprite ROMs.
interface sprite_fetch_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 24
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][4:0]        req_id;
  logic [NUM_REQ-1:0]             gnt;
  logic [ADDR_W-1:0]              rom_addr;
  logic [1:0]                     rom_sel;
  logic [2:0][DATA_W-1:0]         rom_q;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;

  modport master (
    output req, req_addr, req_id, rom_q,
    input  gnt, rom_addr, rom_sel, rsp_valid, rsp_data
  );

  modport slave (
    input  req, req_addr, req_id, rom_q,
    output gnt, rom_addr, rom_sel, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot selector: search starts just above the last-granted bit and wraps.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] gnt
);
  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] mask, hi;

  // Bits strictly above the last grant; last==0 or last==MSB yields an empty mask.
  assign mask = ~((last << 1) - ONE);
  assign hi   = req & mask;
  assign gnt  = (|hi) ? (hi & (~hi + ONE)) : (req & (~req + ONE));

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Shares the sprite ROMs among sprite slots: one round-robin grant per cycle, response
// ROM_LAT cycles later. Define SPRITE_FETCH_STATS_EN to add per-slot stall counters.
module sprite_fetch_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 24,
  parameter int ROM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 line_start,
  sprite_fetch_arbiter_if.slave bus
`ifdef SPRITE_FETCH_STATS_EN
  , output logic [NUM_REQ-1:0][15:0] stall_cnt
`endif
);

  logic [NUM_REQ-1:0] last_gnt, rr_last, rr_gnt, gnt;
  logic               any_gnt;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [4:0]         gnt_id;
  rom_sel_e           gnt_sel;

  // line_start applies reset priority in the very cycle it arrives.
  assign rr_last = line_start ? '0 : last_gnt;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req  (bus.req),
    .last (rr_last),
    .gnt  (rr_gnt)
  );

  assign gnt     = reset_n ? rr_gnt : '0;
  assign any_gnt = |gnt;

  always_comb begin
    gnt_addr = '0;
    gnt_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_addr |= bus.req_addr[i];
        gnt_id   |= bus.req_id[i];
      end
    end
  end

  assign gnt_sel      = any_gnt ? id_to_sel(gnt_id) : SEL_NONE;
  assign bus.gnt      = gnt;
  assign bus.rom_addr = gnt_addr;
  assign bus.rom_sel  = gnt_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        last_gnt <= '0;
    else if (any_gnt)    last_gnt <= gnt;
    else if (line_start) last_gnt <= '0;
  end

  // Stage k holds the grant issued k cycles ago; stage ROM_LAT lines up with rom_q.
  logic [ROM_LAT:1]               vld_pipe;
  logic [ROM_LAT:1][NUM_REQ-1:0]  slot_pipe;
  logic [ROM_LAT:1][1:0]          sel_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      slot_pipe <= '0;
      sel_pipe  <= '0;
    end else begin
      vld_pipe  <= (ROM_LAT)'({vld_pipe, any_gnt});
      slot_pipe <= (ROM_LAT*NUM_REQ)'({slot_pipe, gnt});
      sel_pipe  <= (ROM_LAT*2)'({sel_pipe, gnt_sel});
    end
  end

  logic [DATA_W-1:0] rsp_word;

  always_comb begin
    rsp_word = '0;
    if (vld_pipe[ROM_LAT]) begin
      case (rom_sel_e'(sel_pipe[ROM_LAT]))
        SEL_SHIP: rsp_word = bus.rom_q[0];
        SEL_PIG:  rsp_word = bus.rom_q[1];
        SEL_BEE:  rsp_word = bus.rom_q[2];
        default:  rsp_word = '0;
      endcase
    end
  end

  assign bus.rsp_valid = vld_pipe[ROM_LAT] ? slot_pipe[ROM_LAT] : '0;
  assign bus.rsp_data  = rsp_word;

`ifdef SPRITE_FETCH_STATS_EN
  logic [NUM_REQ-1:0] stall;
  assign stall = bus.req & ~gnt;

  // The line_start cycle itself counts toward the new line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (line_start)
          stall_cnt[i] <= {15'd0, stall[i]};
        else if (stall[i] && stall_cnt[i] != 16'hFFFF)
          stall_cnt[i] <= stall_cnt[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Self-checking bench for sprite_fetch_arbiter: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_sprite_fetch_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 24;
  localparam int ROM_LAT = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic line_start = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  sprite_fetch_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef SPRITE_FETCH_STATS_EN
  logic [NUM_REQ-1:0][15:0] stall_cnt;
`endif

  sprite_fetch_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .line_start (line_start),
    .bus        (bus)
`ifdef SPRITE_FETCH_STATS_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ROM contents: distinct, never-zero words per ROM and address.
  function automatic logic [DATA_W-1:0] rom_word(input int rom, input logic [ADDR_W-1:0] a);
    return {4'(rom + 1), a, a ^ 10'h3C5};
  endfunction

  // ROM model: three synchronous ROMs sharing one address, ROM_LAT cycles of latency.
  logic [ADDR_W-1:0] addr_hist [ROM_LAT];
  always @(posedge clk) begin
    addr_hist[0] <= bus.rom_addr;
    for (int k = 1; k < ROM_LAT; k++) addr_hist[k] <= addr_hist[k-1];
  end
  always_comb begin
    bus.rom_q = '0;
    for (int r = 0; r < 3; r++) bus.rom_q[r] = rom_word(r, addr_hist[ROM_LAT-1]);
  end

  function automatic logic [1:0] exp_sel(input logic [4:0] id);
    if (id == 5'd0) return 2'd0;
    if (id == 5'd2) return 2'd1;
    if (id == 5'd3) return 2'd2;
    return 2'd3;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req = '1;
    bus.req_addr = '1;
    bus.req_id = '0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (bus.gnt !== 3'b000 || bus.rsp_valid !== 3'b000 || bus.rom_sel !== 2'd3 ||
          bus.rom_addr !== '0 || bus.rsp_data !== '0) begin
        errors++;
        $display("FAIL reset_state: gnt=%b rsp_valid=%b rom_sel=%0d rom_addr=%h rsp_data=%h, want 000/000/3/0/0",
                 bus.gnt, bus.rsp_valid, bus.rom_sel, bus.rom_addr, bus.rsp_data);
      end
    end
    next_cycle();
    reset_n = 1'b1;
    bus.req = '0;
    repeat (10) begin
      @(negedge clk);
      vectors++;
      if (bus.gnt !== 3'b000 || bus.rsp_valid !== 3'b000 || bus.rom_sel !== 2'd3) begin
        errors++;
        $display("FAIL idle_after_reset: gnt=%b rsp_valid=%b rom_sel=%0d, want 000/000/3",
                 bus.gnt, bus.rsp_valid, bus.rom_sel);
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [NUM_REQ-1:0] eg, ev;
    logic [DATA_W-1:0]  ed;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i] = ADDR_W'(10'h010 + i);
      bus.req_id[i]   = 5'd0;
    end
    line_start = 1'b1;
    bus.req = 3'b111;
    for (int c = 0; c < 6 + ROM_LAT; c++) begin
      if (c == 6) bus.req = '0;
      eg = (c < 6) ? seq[c] : '0;
      ev = '0;
      ed = '0;
      if (c >= ROM_LAT && c - ROM_LAT < 6) begin
        ev = seq[c-ROM_LAT];
        for (int i = 0; i < NUM_REQ; i++)
          if (ev[i]) ed = rom_word(0, ADDR_W'(10'h010 + i));
      end
      @(negedge clk);
      vectors++;
      if (bus.gnt !== eg || bus.rsp_valid !== ev || bus.rsp_data !== ed) begin
        errors++;
        $display("FAIL round_robin c=%0d: gnt=%b rsp_valid=%b rsp_data=%h, want %b/%b/%h",
                 c, bus.gnt, bus.rsp_valid, bus.rsp_data, eg, ev, ed);
      end
      next_cycle();
      line_start = 1'b0;
    end
  endtask

  task automatic test_pig();
    bus.req = 3'b010;
    bus.req_id[1] = 5'd2;
    bus.req_addr[1] = 10'h155;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 3'b010 || bus.rom_sel !== 2'd1 || bus.rom_addr !== 10'h155) begin
      errors++;
      $display("FAIL pig_grant: gnt=%b rom_sel=%0d rom_addr=%h, want 010/1/155",
               bus.gnt, bus.rom_sel, bus.rom_addr);
    end
    for (int k = 1; k <= ROM_LAT; k++) begin
      next_cycle();
      bus.req = '0;
      @(negedge clk);
      vectors++;
      if (k < ROM_LAT) begin
        if (bus.rsp_valid !== 3'b000) begin
          errors++;
          $display("FAIL pig_early_rsp k=%0d: rsp_valid=%b, want 000", k, bus.rsp_valid);
        end
      end else if (bus.rsp_valid !== 3'b010 || bus.rsp_data !== rom_word(1, 10'h155)) begin
        errors++;
        $display("FAIL pig_rsp: rsp_valid=%b rsp_data=%h, want 010/%h",
                 bus.rsp_valid, bus.rsp_data, rom_word(1, 10'h155));
      end
    end
    next_cycle();
  endtask

  task automatic test_bad_id();
    bus.req = 3'b001;
    bus.req_id[0] = 5'd7;
    bus.req_addr[0] = 10'h2AA;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 3'b001 || bus.rom_sel !== 2'd3 || bus.rom_addr !== 10'h2AA) begin
      errors++;
      $display("FAIL bad_id_grant: gnt=%b rom_sel=%0d rom_addr=%h, want 001/3/2aa",
               bus.gnt, bus.rom_sel, bus.rom_addr);
    end
    next_cycle();
    bus.req = '0;
    @(negedge clk);
    vectors++;
    if (bus.rom_sel !== 2'd3 || bus.rom_addr !== '0) begin
      errors++;
      $display("FAIL idle_bus: rom_sel=%0d rom_addr=%h, want 3/0", bus.rom_sel, bus.rom_addr);
    end
    repeat (ROM_LAT - 1) next_cycle();
    @(negedge clk);
    vectors++;
    if (bus.rsp_valid !== 3'b001 || bus.rsp_data !== '0) begin
      errors++;
      $display("FAIL bad_id_rsp: rsp_valid=%b rsp_data=%h, want 001/0", bus.rsp_valid, bus.rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_line_start_prio();
    logic [NUM_REQ-1:0] rq  [4] = '{3'b010, 3'b110, 3'b010, 3'b110};
    logic               ls  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [NUM_REQ-1:0] exg [4] = '{3'b010, 3'b100, 3'b010, 3'b010};
    for (int i = 0; i < NUM_REQ; i++) bus.req_id[i] = 5'd3;
    for (int s = 0; s < 4; s++) begin
      bus.req = rq[s];
      line_start = ls[s];
      @(negedge clk);
      vectors++;
      if (bus.gnt !== exg[s]) begin
        errors++;
        $display("FAIL line_start_prio step=%0d: gnt=%b, want %b", s, bus.gnt, exg[s]);
      end
      next_cycle();
    end
    bus.req = '0;
    line_start = 1'b0;
    repeat (ROM_LAT + 1) next_cycle();
  endtask

  task automatic test_reset_flush();
    bus.req = 3'b001;
    bus.req_id[0] = 5'd0;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 3'b001) begin
      errors++;
      $display("FAIL flush_grant: gnt=%b, want 001", bus.gnt);
    end
    next_cycle();
    reset_n = 1'b0;
    bus.req = '0;
    next_cycle();
    reset_n = 1'b1;
    repeat (ROM_LAT + 2) begin
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid !== 3'b000 || bus.rsp_data !== '0) begin
        errors++;
        $display("FAIL flush_rsp: rsp_valid=%b rsp_data=%h, want 000/0", bus.rsp_valid, bus.rsp_data);
      end
      next_cycle();
    end
    bus.req = 3'b011;
    @(negedge clk);
    vectors++;
    if (bus.gnt !== 3'b001) begin
      errors++;
      $display("FAIL flush_pointer: gnt=%b, want 001", bus.gnt);
    end
    next_cycle();
    bus.req = '0;
    repeat (ROM_LAT + 1) next_cycle();
  endtask

`ifdef SPRITE_FETCH_STATS_EN
  task automatic test_stats();
    bus.req = 3'b111;
    line_start = 1'b1;
    repeat (3) begin
      next_cycle();
      line_start = 1'b0;
    end
    bus.req = '0;
    @(negedge clk);
    vectors++;
    if (stall_cnt[2] !== 16'd2) begin
      errors++;
      $display("FAIL stall_cnt: slot2=%0d, want 2", stall_cnt[2]);
    end
    repeat (ROM_LAT + 1) next_cycle();
  endtask
`endif

  typedef struct {
    int                 due;
    logic [NUM_REQ-1:0] slot;
    logic [DATA_W-1:0]  data;
  } exp_rsp_t;

  task automatic test_random();
    localparam int NCYC = 400;
    logic [4:0] id_tbl [10] = '{5'd0, 5'd2, 5'd3, 5'd0, 5'd2, 5'd3, 5'd1, 5'd7, 5'd31, 5'd4};
    exp_rsp_t q [$];
    exp_rsp_t e;
    int ptr = -1;
    int gi, idx;
    logic [NUM_REQ-1:0] rq, eg, ev;
    logic [ADDR_W-1:0]  ea;
    logic [1:0]         es;
    logic [DATA_W-1:0]  ed;
    logic               ls;
    for (int c = 0; c < NCYC + ROM_LAT; c++) begin
      rq = (c < NCYC) ? NUM_REQ'($urandom_range(0, 7)) : '0;
      ls = (c == 0) || ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.req_addr[i] = ADDR_W'($urandom);
        bus.req_id[i]   = id_tbl[$urandom_range(0, 9)];
      end
      bus.req = rq;
      line_start = ls;
      if (ls) ptr = -1;
      eg = '0; ea = '0; es = 2'd3; gi = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (ptr + k + NUM_REQ) % NUM_REQ;
        if (gi < 0 && rq[idx]) begin
          gi = idx;
          eg[idx] = 1'b1;
          ea = bus.req_addr[idx];
          es = exp_sel(bus.req_id[idx]);
        end
      end
      if (gi >= 0) begin
        ptr = gi;
        e.due  = c + ROM_LAT;
        e.slot = eg;
        e.data = (es == 2'd3) ? '0 : rom_word(int'(es), ea);
        q.push_back(e);
      end
      ev = '0; ed = '0;
      if (q.size() > 0 && q[0].due == c) begin
        ev = q[0].slot;
        ed = q[0].data;
        void'(q.pop_front());
      end
      @(negedge clk);
      vectors++;
      if (bus.gnt !== eg || bus.rom_addr !== ea || bus.rom_sel !== es) begin
        errors++;
        $display("FAIL rand_grant c=%0d: gnt=%b rom_addr=%h rom_sel=%0d, want %b/%h/%0d",
                 c, bus.gnt, bus.rom_addr, bus.rom_sel, eg, ea, es);
      end
      vectors++;
      if (bus.rsp_valid !== ev || bus.rsp_data !== ed) begin
        errors++;
        $display("FAIL rand_rsp c=%0d: rsp_valid=%b rsp_data=%h, want %b/%h",
                 c, bus.rsp_valid, bus.rsp_data, ev, ed);
      end
      next_cycle();
    end
    line_start = 1'b0;
  endtask

  initial begin
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_id = '0;
    test_reset();
    test_round_robin();
    test_pig();
    test_bad_id();
    test_line_start_prio();
    test_reset_flush();
`ifdef SPRITE_FETCH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
